// File: rtl/kernel_bc_sched_pkg.sv
// Shared types and width helpers for the kernel start-token scheduler.
package kernel_bc_sched_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int DEF_MAX_OUT = 3;

    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int m);
        return $clog2(m + 1);
    endfunction

    function automatic int tot_w(input int n, input int m);
        return $clog2(n * m + 1);
    endfunction

endpackage

// File: rtl/kernel_bc_rr_arbiter.sv
// Combinational rotate-priority arbiter: first eligible requester at or after ptr wins.
module kernel_bc_rr_arbiter
    import kernel_bc_sched_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = id_w(N)
) (
    input  logic [N-1:0]    eligible,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant_onehot,
    output logic [ID_W-1:0] grant_id
);

    logic found;

    always_comb begin
        grant_onehot = '0;
        grant_id     = '0;
        found        = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && eligible[(int'(ptr) + k) % N]) begin
                found                                 = 1'b1;
                grant_onehot[(int'(ptr) + k) % N]     = 1'b1;
                grant_id                              = ID_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/kernel_bc_start_token_sched.sv
// Round-robin start-token scheduler with per-requester credit limits and a drain FSM.
module kernel_bc_start_token_sched
    import kernel_bc_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_w(NUM_REQ),
    parameter int MAX_OUT = DEF_MAX_OUT,
    parameter int CNT_W   = cnt_w(MAX_OUT),
    parameter int TOT_W   = tot_w(NUM_REQ, MAX_OUT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               drain_req,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic               fifo_full_n,
    output logic               fifo_write,
    output logic [ID_W-1:0]    fifo_din,
    input  logic               done_valid,
    input  logic [ID_W-1:0]    done_id,
    output logic               busy,
    output logic               drain_done,
    output logic [TOT_W-1:0]   outstanding_total,
    output logic               err_underflow
);

    state_t                           state_q;
    logic                             drain_done_q;
    logic [NUM_REQ-1:0][CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]                  rr_ptr_q, rr_ptr_d;
    logic [TOT_W-1:0]                 tot_q, tot_d;
    logic                             err_q, err_d;
    logic [NUM_REQ-1:0]               eligible, grant_oh, done_hit;
    logic [ID_W-1:0]                  grant_id;
    logic                             grant_en, underflow;

    kernel_bc_rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
        .eligible     (eligible),
        .ptr          (rr_ptr_q),
        .grant_onehot (grant_oh),
        .grant_id     (grant_id)
    );

    // A drain request in RUN wins over any grant in the same cycle.
    assign grant_en   = (state_q == S_RUN) && enable && !drain_req && fifo_full_n;
    assign req_ready  = grant_en ? grant_oh : '0;
    assign fifo_write = |req_ready;
    assign fifo_din   = fifo_write ? grant_id : '0;

    always_comb begin
        underflow = done_valid && (int'(done_id) >= NUM_REQ);
        done_hit  = '0;
        tot_d     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (int'(cnt_q[i]) < MAX_OUT);
            if (done_valid && (done_id == ID_W'(i))) begin
                if (cnt_q[i] != '0) done_hit[i] = 1'b1;
                else                underflow   = 1'b1;
            end
            cnt_d[i] = cnt_q[i] + CNT_W'(req_ready[i]) - CNT_W'(done_hit[i]);
            tot_d    = tot_d + TOT_W'(cnt_d[i]);
        end
        rr_ptr_d = fifo_write ? ID_W'((int'(grant_id) + 1) % NUM_REQ) : rr_ptr_q;
        err_d    = err_q | underflow;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            tot_q    <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            tot_q    <= tot_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    // Drain completion is judged on the registered total, so it lands 2 cycles after the last done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            drain_done_q <= 1'b0;
        end else begin
            drain_done_q <= 1'b0;
            case (state_q)
                S_IDLE:  if (enable) state_q <= S_RUN;
                S_RUN: begin
                    if (drain_req)    state_q <= S_DRAIN;
                    else if (!enable) state_q <= S_IDLE;
                end
                S_DRAIN: begin
                    if (tot_q == '0) begin
                        state_q      <= S_DONE;
                        drain_done_q <= 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy              = (state_q != S_IDLE) || (tot_q != '0);
    assign drain_done        = drain_done_q;
    assign outstanding_total = tot_q;
    assign err_underflow     = err_q;

endmodule

// File: tb/tb_kernel_bc_start_token_sched.sv
// Directed and randomized bench for the start-token scheduler against a queue-free behavioural model.
module tb_kernel_bc_start_token_sched;

    localparam int NR  = 4;
    localparam int MAX = 3;

    logic        clk = 1'b0;
    logic        reset, enable, drain_req, fifo_full_n, done_valid;
    logic [3:0]  req_valid, req_ready;
    logic        fifo_write, busy, drain_done, err_underflow;
    logic [1:0]  fifo_din, done_id;
    logic [3:0]  outstanding_total;

    int n_cmp  = 0;
    int n_fail = 0;
    int writes = 0;

    // Model: 0=idle 1=run 2=drain 3=done; per-requester outstanding counts.
    int m_state, m_rr, m_err;
    int m_cnt[NR];

    always #5 clk = ~clk;

    kernel_bc_start_token_sched dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .drain_req         (drain_req),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .fifo_full_n       (fifo_full_n),
        .fifo_write        (fifo_write),
        .fifo_din          (fifo_din),
        .done_valid        (done_valid),
        .done_id           (done_id),
        .busy              (busy),
        .drain_done        (drain_done),
        .outstanding_total (outstanding_total),
        .err_underflow     (err_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_rr    = 0;
        m_err   = 0;
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; drain_req = 1'b0; req_valid = '0;
        fifo_full_n = 1'b1; done_valid = 1'b0; done_id = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic cyc(input logic en, input logic dr, input logic [3:0] rv,
                       input logic ff, input logic dv, input logic [1:0] did);
        int win, tot, idx;
        logic [3:0] exp_rdy;
        enable = en; drain_req = dr; req_valid = rv; fifo_full_n = ff;
        done_valid = dv; done_id = did;
        @(negedge clk);
        win = -1;
        tot = 0;
        for (int i = 0; i < NR; i++) tot += m_cnt[i];
        if (m_state == 1 && en && !dr && ff) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_rr + k) % NR;
                if (win < 0 && rv[idx] && m_cnt[idx] < MAX) win = idx;
            end
        end
        exp_rdy = (win >= 0) ? 4'(1 << win) : 4'b0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("fifo_write", 32'(fifo_write), 32'(win >= 0));
        if (win >= 0) chk("fifo_din", 32'(fifo_din), 32'(win));
        chk("outstanding_total", 32'(outstanding_total), 32'(tot));
        chk("busy", 32'(busy), 32'(m_state != 0 || tot != 0));
        chk("drain_done", 32'(drain_done), 32'(m_state == 3));
        chk("err_underflow", 32'(err_underflow), 32'(m_err));
        if (fifo_write === 1'b1) writes++;
        if (dv) begin
            if (m_cnt[did] > 0) m_cnt[did]--;
            else                m_err = 1;
        end
        if (win >= 0) begin
            m_cnt[win]++;
            m_rr = (win + 1) % NR;
        end
        case (m_state)
            0: if (en) m_state = 1;
            1: if (dr) m_state = 2; else if (!en) m_state = 0;
            2: if (tot == 0) m_state = 3;
            default: m_state = 0;
        endcase
        @(posedge clk); #1;
    endtask

    initial begin
        logic       r_en, r_dr, r_ff, r_dv;
        logic [3:0] r_rv;
        logic [1:0] r_id;

        // All four requesting: grants rotate 0,1,2,3.
        do_reset();
        cyc(1, 0, 4'b0000, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 4'b1111, 1, 0, 0);
        chk("p1_total", 32'(outstanding_total), 32'd4);

        // Credit limit on requester 2, then one completion frees one more grant.
        do_reset();
        cyc(1, 0, 4'b0000, 1, 0, 0);
        writes = 0;
        for (int i = 0; i < 5; i++) cyc(1, 0, 4'b0100, 1, 0, 0);
        chk("p2_writes", 32'(writes), 32'd3);
        cyc(1, 0, 4'b0100, 1, 1, 2);
        cyc(1, 0, 4'b0100, 1, 0, 0);
        chk("p2_writes_after_done", 32'(writes), 32'd4);

        // FIFO full holds the pointer; then 0 and 2 are granted in order.
        do_reset();
        cyc(1, 0, 4'b0000, 1, 0, 0);
        cyc(1, 0, 4'b0101, 0, 0, 0);
        cyc(1, 0, 4'b0101, 0, 0, 0);
        cyc(1, 0, 4'b0101, 1, 0, 0);
        cyc(1, 0, 4'b0101, 1, 0, 0);

        // Grant and completion for requester 1 in the same cycle.
        do_reset();
        cyc(1, 0, 4'b0000, 1, 0, 0);
        cyc(1, 0, 4'b0010, 1, 0, 0);
        cyc(1, 0, 4'b0010, 1, 0, 0);
        cyc(1, 0, 4'b0010, 1, 1, 1);
        cyc(1, 0, 4'b0000, 1, 0, 0);
        chk("p4_total", 32'(outstanding_total), 32'd2);

        // Drain with three tokens out.
        do_reset();
        cyc(1, 0, 4'b0000, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 4'b0111, 1, 0, 0);
        cyc(1, 1, 4'b0111, 1, 0, 0);
        cyc(1, 0, 4'b0111, 1, 1, 0);
        cyc(1, 0, 4'b0111, 1, 1, 1);
        cyc(1, 0, 4'b0111, 1, 1, 2);
        cyc(0, 0, 4'b0000, 1, 0, 0);
        cyc(0, 0, 4'b0000, 1, 0, 0);
        cyc(0, 0, 4'b0000, 1, 0, 0);
        chk("p5_busy", 32'(busy), 32'd0);

        // Underflow is sticky; a mid-run reset clears counts and the flag.
        do_reset();
        cyc(1, 0, 4'b0000, 1, 0, 0);
        cyc(1, 0, 4'b0000, 1, 1, 3);
        cyc(1, 0, 4'b0011, 1, 0, 0);
        cyc(1, 0, 4'b0011, 1, 0, 0);
        chk("p6_err_held", 32'(err_underflow), 32'd1);
        do_reset();
        cyc(1, 0, 4'b1111, 1, 0, 0);
        chk("p6_total_after_reset", 32'(outstanding_total), 32'd0);
        chk("p6_err_after_reset", 32'(err_underflow), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            r_en = ($urandom_range(0, 15) != 0);
            r_dr = ($urandom_range(0, 39) == 0);
            r_rv = 4'($urandom);
            r_ff = ($urandom_range(0, 4) != 0);
            r_dv = 1'($urandom);
            r_id = 2'($urandom);
            if (r_dv && m_cnt[r_id] == 0 && $urandom_range(0, 19) != 0) r_dv = 1'b0;
            cyc(r_en, r_dr, r_rv, r_ff, r_dv, r_id);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/kernel_bc_start_token_sched.md
Name: kernel_bc_start_token_sched

Overview:
- Schedules dataflow start tokens from NUM_REQ upstream producer processes into the single shared write-back start-token FIFO.
- Round-robin arbitration, one token per cycle maximum.
- Per-requester credit limit on tokens that have been issued but not yet completed.
- Completions are returned by the write-back stage. A drain/quiesce FSM lets the kernel control stop new starts and wait until all tokens have retired.

Parameters:
- NUM_REQ, 4: number of producer requesters (2..8).
- ID_W, 2: requester ID width, equal to clog2(NUM_REQ).
- MAX_OUT, 3: maximum outstanding tokens per requester (1..15).
- CNT_W, 2: per-requester counter width, equal to clog2(MAX_OUT+1).
- TOT_W, 4: total outstanding counter width, equal to clog2(NUM_REQ*MAX_OUT+1).

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: level. Leaves IDLE and allows grants.
- drain_req, input, 1: pulse. Stop granting and wait for outstanding tokens to reach 0.
- req_valid, input, NUM_REQ: per-requester start request.
- req_ready, output, NUM_REQ: one-hot grant, combinational, same cycle as the write.
- fifo_full_n, input, 1: start FIFO not full.
- fifo_write, output, 1: start FIFO write strobe.
- fifo_din, output, ID_W: ID of the granted requester.
- done_valid, input, 1: write-back completion strobe.
- done_id, input, ID_W: requester ID of the completed token.
- busy, output, 1: high when state != IDLE or total outstanding != 0.
- drain_done, output, 1: single-cycle pulse when the drain completes.
- outstanding_total, output, TOT_W: sum of all per-requester counters.
- err_underflow, output, 1: sticky flag. Set when a completion arrives for a requester whose counter is 0.

Behaviour:
- Reset, synchronous, active-high:
  - state=IDLE; rr_ptr=0; all counters=0; err_underflow=0.
  - Outputs req_ready=0, fifo_write=0, drain_done=0, busy=0.
  - Reset mid-operation discards all counts immediately. Tokens already in the FIFO are not tracked after reset.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN on drain_req=1. drain_req has priority over a grant in the same cycle, so no grant is made that cycle.
  - RUN -> IDLE when enable=0 and no drain is pending.
  - DRAIN -> DONE when outstanding_total==0, evaluated on registered counters. This is checked the cycle after entering DRAIN, or later.
  - DONE -> IDLE unconditionally after 1 cycle. drain_done=1 only in DONE.
  - drain_req in IDLE or DRAIN is ignored.
- Eligibility: requester i is eligible when req_valid[i]=1 and cnt[i] < MAX_OUT.
- Grant, RUN only, fifo_full_n=1, at least one eligible requester:
  - Winner is the first eligible requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Same cycle: req_ready[winner]=1, fifo_write=1, fifo_din=winner.
  - Next cycle: rr_ptr=(winner+1) mod NUM_REQ.
  - Zero-cycle combinational path from req_valid and fifo_full_n to req_ready and fifo_write.
- No grant when fifo_full_n=0, no requester is eligible, or state != RUN. In that case rr_ptr holds.
- Counter update per requester i, registered:
  - +1 on grant to i.
  - -1 on done_valid with done_id==i and cnt[i]>0.
  - Grant and completion for the same i in the same cycle: counter unchanged.
  - done_valid with cnt[done_id]==0: counter stays 0 and err_underflow sets. Cleared only by reset.
  - done_id >= NUM_REQ: same treatment as underflow.
- outstanding_total is the registered sum of all counters. Its widths never wrap because counts are capped at MAX_OUT.
- Latency: request to FIFO write is 0 cycles. Completion to counter decrement is 1 cycle. In DRAIN, last completion to drain_done is 2 cycles.

Decomposition:
- Shared package kernel_bc_sched_pkg contains:
  - state enum {S_IDLE, S_RUN, S_DRAIN, S_DONE};
  - ID_W / CNT_W width functions (clog2);
  - the MAX_OUT default.
- One sub-module, kernel_bc_rr_arbiter: parameter N; inputs eligible[N] and ptr; outputs grant_onehot and grant_id. Purely combinational with rotate-priority logic.
- Counters, FSM and rr_ptr register live in the top module.

Test Plan:
- Reset then enable=1, req_valid=4'b1111, fifo_full_n=1 for 4 cycles -> fifo_din sequence 0,1,2,3; each req_ready one-hot; outstanding_total=4.
- Requester 2 only, MAX_OUT=3, no completions for 5 cycles -> exactly 3 writes, then req_ready[2]=0; done_id=2 pulse -> one further grant the next cycle.
- fifo_full_n=0 with req_valid=4'b0101 -> fifo_write=0, rr_ptr unchanged; fifo_full_n back to 1 -> grant to requester 0 (rr_ptr=0), next cycle requester 2.
- Same-cycle grant to requester 1 and done_id=1, with cnt[1]=2 -> cnt[1] stays 2, outstanding_total unchanged.
- 3 tokens outstanding, drain_req pulse -> no further fifo_write; after 3 completions, drain_done pulses exactly 2 cycles after the last completion, then state is IDLE and busy=0.
- done_valid with done_id=3 while cnt[3]=0 -> err_underflow=1 and held; then reset mid-RUN with tokens outstanding -> all counters 0, err_underflow=0, req_ready=0 in the cycle after reset.
